// File: rtl/cr_rbus_ring_master.sv
// cr_rbus_ring_master: head of the register-bus ring. It accepts one host
// request at a time, launches it as a single-cycle strobe, waits for the
// ring tail to return ack/err_ack (or times out) and hands the result back.
module cr_rbus_ring_master #(
    parameter int N_RBUS_ADDR_BITS = 16,
    parameter int N_RBUS_DATA_BITS = 32,
    parameter int TIMEOUT_CYCLES   = 1024,
    parameter int N_TO_BITS        = 11
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [N_RBUS_ADDR_BITS-1:0] req_addr,
    input  logic [N_RBUS_DATA_BITS-1:0] req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [N_RBUS_DATA_BITS-1:0] rsp_rdata,
    output logic [1:0]                  rsp_status,
    output logic                        busy,
    output logic [7:0]                  stale_ack_cnt,
    output logic [N_RBUS_ADDR_BITS-1:0] rbus_addr_o,
    output logic                        rbus_wr_strb_o,
    output logic                        rbus_rd_strb_o,
    output logic [N_RBUS_DATA_BITS-1:0] rbus_wr_data_o,
    output logic [N_RBUS_DATA_BITS-1:0] rbus_rd_data_o,
    output logic                        rbus_ack_o,
    output logic                        rbus_err_ack_o,
    input  logic [N_RBUS_ADDR_BITS-1:0] rbus_addr_i,
    input  logic                        rbus_wr_strb_i,
    input  logic                        rbus_rd_strb_i,
    input  logic [N_RBUS_DATA_BITS-1:0] rbus_wr_data_i,
    input  logic [N_RBUS_DATA_BITS-1:0] rbus_rd_data_i,
    input  logic                        rbus_ack_i,
    input  logic                        rbus_err_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [N_TO_BITS-1:0] TO_LAST = N_TO_BITS'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_ERR     = 2'b01;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b10;

    state_t                 state;
    state_t                 state_next;
    logic                   wr_q;
    logic [N_TO_BITS-1:0]   timer;
    logic                   accept;
    logic                   timed_out;

    // The initiator is the ring origin, so the response lanes start at zero.
    assign rbus_rd_data_o = '0;
    assign rbus_ack_o     = 1'b0;
    assign rbus_err_ack_o = 1'b0;

    // The request half of the ring tail comes back to us but carries nothing useful.
    logic unused_ring_tail;
    assign unused_ring_tail = ^{rbus_addr_i, rbus_wr_strb_i, rbus_rd_strb_i, rbus_wr_data_i};

    assign accept    = (state == ST_IDLE) && req_valid;
    assign timed_out = (timer == TO_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic: a request walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (rbus_err_ack_i || rbus_ack_i || timed_out) state_next = ST_RESP;
            ST_RESP:  if (rsp_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Host-facing handshake flags decoded from the state.
    always_comb begin
        req_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
        busy      = (state != ST_IDLE);
    end

    // Ring launch registers: loaded on acceptance so they are live only during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbus_addr_o    <= '0;
            rbus_wr_strb_o <= 1'b0;
            rbus_rd_strb_o <= 1'b0;
            rbus_wr_data_o <= '0;
            wr_q           <= 1'b0;
        end else if (accept) begin
            rbus_addr_o    <= req_addr;
            rbus_wr_strb_o <= req_wr;
            rbus_rd_strb_o <= !req_wr;
            rbus_wr_data_o <= req_wr ? req_wdata : '0;
            wr_q           <= req_wr;
        end else begin
            rbus_addr_o    <= '0;
            rbus_wr_strb_o <= 1'b0;
            rbus_rd_strb_o <= 1'b0;
            rbus_wr_data_o <= '0;
        end
    end

    // WAIT timer: cleared while the strobe is out, counts WAIT cycles without a reply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    timer <= '0;
        else if (state == ST_ISSUE) timer <= '0;
        else if (state == ST_WAIT && !rbus_err_ack_i && !rbus_ack_i && !timed_out)
            timer <= timer + 1'b1;
    end

    // Response capture: err_ack beats ack, and both beat the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata  <= '0;
            rsp_status <= STATUS_OK;
        end else if (state == ST_WAIT) begin
            if (rbus_err_ack_i) begin
                rsp_rdata  <= '0;
                rsp_status <= STATUS_ERR;
            end else if (rbus_ack_i) begin
                rsp_rdata  <= wr_q ? '0 : rbus_rd_data_i;
                rsp_status <= STATUS_OK;
            end else if (timed_out) begin
                rsp_rdata  <= '0;
                rsp_status <= STATUS_TIMEOUT;
            end
        end
    end

    // Acks that arrive when nobody is waiting (late after timeout, early in ISSUE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stale_ack_cnt <= '0;
        else if ((rbus_ack_i || rbus_err_ack_i) && state != ST_WAIT && stale_ack_cnt != 8'hFF)
            stale_ack_cnt <= stale_ack_cnt + 8'd1;
    end

endmodule

// File: tb/tb_cr_rbus_ring_master.sv
// Testbench for cr_rbus_ring_master: table-driven directed transactions,
// hand-written reset/saturation sequences and randomized transactions
// predicted by a transaction-level model of the ring protocol.
module tb_cr_rbus_ring_master;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;
    logic        busy;
    logic [7:0]  stale_ack_cnt;
    logic [15:0] rbus_addr_o;
    logic        rbus_wr_strb_o, rbus_rd_strb_o;
    logic [31:0] rbus_wr_data_o, rbus_rd_data_o;
    logic        rbus_ack_o, rbus_err_ack_o;
    logic [15:0] rbus_addr_i;
    logic        rbus_wr_strb_i, rbus_rd_strb_i;
    logic [31:0] rbus_wr_data_i, rbus_rd_data_i;
    logic        rbus_ack_i, rbus_err_ack_i;

    int n_checks = 0;
    int n_err    = 0;
    int exp_stale = 0;

    always #5 clk = ~clk;

    cr_rbus_ring_master #(
        .N_RBUS_ADDR_BITS(16), .N_RBUS_DATA_BITS(32),
        .TIMEOUT_CYCLES(TO), .N_TO_BITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_status(rsp_status),
        .busy(busy), .stale_ack_cnt(stale_ack_cnt),
        .rbus_addr_o(rbus_addr_o), .rbus_wr_strb_o(rbus_wr_strb_o),
        .rbus_rd_strb_o(rbus_rd_strb_o), .rbus_wr_data_o(rbus_wr_data_o),
        .rbus_rd_data_o(rbus_rd_data_o), .rbus_ack_o(rbus_ack_o),
        .rbus_err_ack_o(rbus_err_ack_o),
        .rbus_addr_i(rbus_addr_i), .rbus_wr_strb_i(rbus_wr_strb_i),
        .rbus_rd_strb_i(rbus_rd_strb_i), .rbus_wr_data_i(rbus_wr_data_i),
        .rbus_rd_data_i(rbus_rd_data_i), .rbus_ack_i(rbus_ack_i),
        .rbus_err_ack_i(rbus_err_ack_i)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " req_ready"}, req_ready, 1);
        chk({tag, " rsp_valid"}, rsp_valid, 0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 0);
        chk({tag, " rsp_status"}, rsp_status, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " stale"}, stale_ack_cnt, 0);
        chk({tag, " ring outs"}, {rbus_addr_o, rbus_wr_strb_o, rbus_rd_strb_o, rbus_wr_data_o,
                                  rbus_rd_data_o, rbus_ack_o, rbus_err_ack_o}, 0);
    endtask

    // Transaction-level prediction: the first reply inside the WAIT window
    // (offsets 2 .. TO+1 after the handshake) decides the outcome; none means timeout.
    task automatic model(input logic wr, input logic [31:0] rdv, input logic [15:0] ackm,
                         input logic [15:0] errm, output int rsp, output logic [1:0] st,
                         output logic [31:0] rd);
        rsp = TO + 2; st = 2'b10; rd = 0;
        for (int d = 2; d <= TO + 1; d++) begin
            if (ackm[d] || errm[d]) begin
                rsp = d + 1;
                st  = errm[d] ? 2'b01 : 2'b00;
                rd  = (errm[d] || wr) ? 32'h0 : rdv;
                break;
            end
        end
    endtask

    // Runs one transaction starting at a negedge with the DUT idle. Offset 0 is the
    // handshake cycle; ackm/errm give the ring replies per offset; the host takes the
    // response hold cycles after it appears.
    task automatic run_txn(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdv, input logic [15:0] ackm, input logic [15:0] errm,
                           input int hold, input int exp_rsp, input logic [1:0] exp_st,
                           input logic [31:0] exp_rd, input bit pulse_req);
        int r_cyc;
        int nack;
        logic a, e;
        r_cyc = exp_rsp + hold;
        nack  = 0;
        for (int off = 0; off <= r_cyc; off++) begin
            a = (off < 16) ? ackm[off] : 1'b0;
            e = (off < 16) ? errm[off] : 1'b0;
            req_valid      = (off == 0) ? 1'b1 : (pulse_req ? 1'($urandom_range(0, 1)) : 1'b0);
            req_wr         = (off == 0) ? wr : 1'($urandom_range(0, 1));
            req_addr       = (off == 0) ? addr : 16'($urandom);
            req_wdata      = (off == 0) ? wdata : $urandom;
            rbus_ack_i     = a;
            rbus_err_ack_i = e;
            rbus_rd_data_i = rdv;
            rsp_ready      = (off >= r_cyc);
            if (a || e) nack++;
            chk("req_ready", req_ready, off == 0);
            chk("busy", busy, off != 0);
            chk("wr_strb", rbus_wr_strb_o, (off == 1) && wr);
            chk("rd_strb", rbus_rd_strb_o, (off == 1) && !wr);
            chk("ring_addr", rbus_addr_o, (off == 1) ? addr : 16'h0);
            if (off != 1 || wr)
                chk("ring_wdata", rbus_wr_data_o, (off == 1) ? wdata : 32'h0);
            chk("rsp_valid", rsp_valid, off >= exp_rsp);
            if (off >= exp_rsp) begin
                chk("rsp_status", rsp_status, exp_st);
                chk("rsp_rdata", rsp_rdata, exp_rd);
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 0; rbus_ack_i = 0; rbus_err_ack_i = 0; rsp_ready = 0;
        exp_stale = exp_stale + nack - ((exp_st != 2'b10) ? 1 : 0);
        if (exp_stale > 255) exp_stale = 255;
        chk("idle rsp_valid", rsp_valid, 0);
        chk("idle req_ready", req_ready, 1);
        chk("stale_cnt", stale_ack_cnt, exp_stale);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdv;
        logic [15:0] ackm;
        logic [15:0] errm;
        int          hold;
        int          rsp;
        logic [1:0]  st;
        logic [31:0] rd;
        bit          pulse;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          m_rsp;
        logic [1:0]  m_st;
        logic [31:0] m_rd;
        logic        wr;
        logic [31:0] rdv;
        logic [15:0] am, em;

        // Offsets are cycles after the handshake; WAIT covers offsets 2..9 for TO = 8.
        vecs[0] = '{1'b1, 16'h0040, 32'hA5A5_0001, 32'h0,         16'h0020, 16'h0,    0,  6, 2'b00, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 16'h0100, 32'h0,         32'h1234_5678, 16'h0004, 16'h0,    0,  3, 2'b00, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 16'h0104, 32'h0,         32'hFFFF_FFFF, 16'h0010, 16'h0010, 1,  5, 2'b01, 32'h0,         1'b0};
        vecs[3] = '{1'b0, 16'hBEEF, 32'h0,         32'h7777_7777, 16'h1000, 16'h0,    3, 10, 2'b10, 32'h0,         1'b0};
        vecs[4] = '{1'b0, 16'h0108, 32'h0,         32'hCAFE_F00D, 16'h0008, 16'h0,    0,  4, 2'b00, 32'hCAFE_F00D, 1'b0};
        vecs[5] = '{1'b0, 16'h010C, 32'h0,         32'h0BAD_BEEF, 16'h0004, 16'h0,    20, 3, 2'b00, 32'h0BAD_BEEF, 1'b1};
        vecs[6] = '{1'b1, 16'h0200, 32'h1111_2222, 32'h3333_4444, 16'h0,    16'h0004, 0,  3, 2'b01, 32'h0,         1'b0};
        vecs[7] = '{1'b0, 16'h0204, 32'h0,         32'h0F0F_0F0F, 16'h000A, 16'h0,    0,  4, 2'b00, 32'h0F0F_0F0F, 1'b0};
        vecs[8] = '{1'b0, 16'h0208, 32'h0,         32'h55AA_55AA, 16'h0200, 16'h0,    0, 10, 2'b00, 32'h55AA_55AA, 1'b0};
        vecs[9] = '{1'b1, 16'h020C, 32'h9999_0000, 32'hDEAD_BEEF, 16'h0004, 16'h0,    2,  3, 2'b00, 32'h0,         1'b0};

        rst = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
        rbus_addr_i = 16'h5A5A; rbus_wr_strb_i = 1; rbus_rd_strb_i = 1; rbus_wr_data_i = 32'hC0DE;
        rbus_rd_data_i = 0; rbus_ack_i = 0; rbus_err_ack_i = 0;
        repeat (3) @(negedge clk);
        chk_reset_values("in reset");
        rst = 0;
        @(negedge clk);
        chk_reset_values("after reset");

        for (int i = 0; i < 10; i++)
            run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdv, vecs[i].ackm,
                    vecs[i].errm, vecs[i].hold, vecs[i].rsp, vecs[i].st, vecs[i].rd, vecs[i].pulse);

        // Randomized transactions against the model.
        for (int i = 0; i < 60; i++) begin
            wr  = 1'($urandom_range(0, 1));
            rdv = $urandom;
            am  = 16'($urandom & $urandom & $urandom);
            em  = 16'($urandom & $urandom & $urandom & $urandom);
            model(wr, rdv, am, em, m_rsp, m_st, m_rd);
            run_txn(wr, 16'($urandom), $urandom, rdv, am, em, $urandom_range(0, 3),
                    m_rsp, m_st, m_rd, 1'($urandom_range(0, 1)));
        end

        // Stale counter saturation: acks while idle for more cycles than the counter holds.
        for (int i = 0; i < 300; i++) begin
            rbus_ack_i     = (i % 2 == 0);
            rbus_err_ack_i = (i % 3 == 0);
            if (rbus_ack_i || rbus_err_ack_i) exp_stale++;
            @(negedge clk);
        end
        rbus_ack_i = 0; rbus_err_ack_i = 0;
        if (exp_stale > 255) exp_stale = 255;
        chk("stale saturated", stale_ack_cnt, exp_stale);

        // Reset in the middle of WAIT.
        req_valid = 1; req_wr = 0; req_addr = 16'h0300;
        @(negedge clk);
        req_valid = 0;
        repeat (2) @(negedge clk);
        chk("busy before reset", busy, 1);
        @(posedge clk);
        #2 rst = 1;
        #1 chk_reset_values("async reset");
        @(negedge clk);
        rst = 0;
        rbus_ack_i = 1;
        @(negedge clk);
        rbus_ack_i = 0;
        exp_stale = 1;
        chk("stale after reset", stale_ack_cnt, 1);
        run_txn(1'b1, 16'h0044, 32'h0BEE_F00D, 32'h1, 16'h0004, 16'h0, 0, 3, 2'b00, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
